ram_arbiter: RTL and testbench

Two-port round-robin arbiter and sequencer for the 16 x 16-bit single-port block RAM in the memory read/write experiment. After reset it clears the whole array, then shares the single RAM port between two requesters through a req/gnt handshake. It drives the RAM's `ena`/`wea`/`addr`/`din` pins and returns read data with a per-port valid strobe. It sits between the RAM IP and the write-sequencer and display-reader logic.

---
 rtl/ram_arbiter.sv | 127 ++++++++++++
 tb/tb_ram_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Round-robin two-port arbiter and clear sequencer for a single-port block RAM.
// Clears the whole array after reset (or on request), then shares the RAM port between two requesters.
module ram_arbiter #(
   parameter int                 ADDR_W  = 4,
   parameter int                 DATA_W  = 16,
   parameter int                 RD_LAT  = 1,
   parameter logic [DATA_W-1:0]  CLR_VAL = '0
) (
   input  logic              clk_in,
   input  logic              rst,
   input  logic              clr,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic              init_done,
   output logic              ram_ena,
   output logic              ram_wea,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_din,
   input  logic [DATA_W-1:0] ram_dout
);

   typedef enum logic {CLEAR = 1'b0, ARB = 1'b1} state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

   state_t              r_state;
   state_t              w_nextState;
   logic [ADDR_W-1:0]   r_clrAddr;
   logic                r_prio;
   logic                r_ramEna;
   logic                r_ramWea;
   logic [ADDR_W-1:0]   r_ramAddr;
   logic [DATA_W-1:0]   r_ramDin;
   logic [RD_LAT:0]     r_rdPipe0;
   logic [RD_LAT:0]     r_rdPipe1;
   logic                w_arb;
   logic                w_gnt0;
   logic                w_gnt1;

   // A pending clear request masks both grants in the same cycle it is seen.
   assign w_arb  = (r_state == ARB);
   assign w_gnt0 = w_arb & ~clr & req0 & (~req1 | ~r_prio);
   assign w_gnt1 = w_arb & ~clr & req1 & (~req0 |  r_prio);

   assign gnt0      = w_gnt0;
   assign gnt1      = w_gnt1;
   assign init_done = w_arb;
   assign ram_ena   = r_ramEna;
   assign ram_wea   = r_ramWea;
   assign ram_addr  = r_ramAddr;
   assign ram_din   = r_ramDin;
   assign rvalid0   = r_rdPipe0[RD_LAT];
   assign rvalid1   = r_rdPipe1[RD_LAT];
   assign rdata0    = ram_dout;
   assign rdata1    = ram_dout;

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         CLEAR:   if (r_clrAddr == LAST_ADDR) w_nextState = ARB;
         ARB:     if (clr) w_nextState = CLEAR;
         default: w_nextState = CLEAR;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) r_state <= CLEAR;
      else      r_state <= w_nextState;
   end

   // RAM command register; the clear counter wraps back to 0 on its last write.
   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         r_clrAddr <= '0;
         r_prio    <= 1'b0;
         r_ramEna  <= 1'b0;
         r_ramWea  <= 1'b0;
         r_ramAddr <= '0;
         r_ramDin  <= '0;
      end else if (r_state == CLEAR) begin
         r_ramEna  <= 1'b1;
         r_ramWea  <= 1'b1;
         r_ramAddr <= r_clrAddr;
         r_ramDin  <= CLR_VAL;
         r_clrAddr <= r_clrAddr + ADDR_W'(1);
      end else if (w_gnt0) begin
         r_ramEna  <= 1'b1;
         r_ramWea  <= we0;
         r_ramAddr <= addr0;
         r_ramDin  <= wdata0;
         r_prio    <= 1'b1;
      end else if (w_gnt1) begin
         r_ramEna  <= 1'b1;
         r_ramWea  <= we1;
         r_ramAddr <= addr1;
         r_ramDin  <= wdata1;
         r_prio    <= 1'b0;
      end else begin
         r_ramEna  <= 1'b0;
         r_ramWea  <= 1'b0;
      end
   end

   // Read-return tags keep shifting in every state so reads in flight across a clear still complete.
   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         r_rdPipe0 <= '0;
         r_rdPipe1 <= '0;
      end else begin
         r_rdPipe0 <= {r_rdPipe0[RD_LAT-1:0], w_gnt0 & ~we0};
         r_rdPipe1 <= {r_rdPipe1[RD_LAT-1:0], w_gnt1 & ~we1};
      end
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: behavioural RAM, transaction-level reference model,
// directed scenarios from the feature list plus a randomized two-requester phase.
module tb_ram_arbiter;

   localparam int ADDR_W = 4;
   localparam int DATA_W = 16;
   localparam int RD_LAT = 1;
   localparam int DEPTH  = 16;

   logic              clk_in = 1'b0;
   logic              rst    = 1'b0;
   logic              clr    = 1'b0;
   logic              req0   = 1'b0;
   logic              req1   = 1'b0;
   logic              we0    = 1'b0;
   logic              we1    = 1'b0;
   logic [ADDR_W-1:0] addr0  = '0;
   logic [ADDR_W-1:0] addr1  = '0;
   logic [DATA_W-1:0] wdata0 = '0;
   logic [DATA_W-1:0] wdata1 = '0;
   logic              gnt0, gnt1, rvalid0, rvalid1, init_done, ram_ena, ram_wea;
   logic [DATA_W-1:0] rdata0, rdata1, ram_din;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ramDout = '0;
   logic [DATA_W-1:0] ramArray [DEPTH];

   ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .CLR_VAL('0)) dut (
      .clk_in(clk_in), .rst(rst), .clr(clr),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rdata0(rdata0), .rdata1(rdata1), .init_done(init_done),
      .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_addr(ram_addr), .ram_din(ram_din),
      .ram_dout(ramDout)
   );

   always #5 clk_in = ~clk_in;

   // Write-first single-port block RAM with one clock of read latency.
   always @(posedge clk_in) begin
      if (ram_ena) begin
         if (ram_wea) begin
            ramArray[ram_addr] <= ram_din;
            ramDout            <= ram_din;
         end else begin
            ramDout <= ramArray[ram_addr];
         end
      end
   end

   typedef struct {
      int                port;
      int                due;
      logic [DATA_W-1:0] data;
   } rd_t;

   // Reference model: memory contents, arbitration pointer and reads awaiting return.
   rd_t               rdQ[$];
   bit                mArb;
   int                mClrIdx;
   bit                mPrio;
   logic [DATA_W-1:0] mMem [DEPTH];
   logic              expEna, expWea;
   logic [ADDR_W-1:0] expAddr;
   logic [DATA_W-1:0] expDin;
   int                cyc;
   int                nChecks;
   int                nErrors;
   bit                lastG0, lastG1;
   logic              dutG0, dutG1;

   task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nErrors++;
         $display("[TB] FAIL %s at t=%0t: got %0h, expected %0h", tag, $time, act, exp);
      end
   endtask

   task automatic modelReset();
      mArb    = 1'b0;
      mClrIdx = 0;
      mPrio   = 1'b0;
      expEna  = 1'b0;
      expWea  = 1'b0;
      expAddr = '0;
      expDin  = '0;
      rdQ.delete();
      foreach (mMem[i]) mMem[i] = '0;
   endtask

   task automatic checkResetState();
      checkOutput("rst_ram_ena",   ram_ena,   0);
      checkOutput("rst_ram_wea",   ram_wea,   0);
      checkOutput("rst_ram_addr",  ram_addr,  0);
      checkOutput("rst_ram_din",   ram_din,   0);
      checkOutput("rst_init_done", init_done, 0);
      checkOutput("rst_gnt0",      gnt0,      0);
      checkOutput("rst_gnt1",      gnt1,      0);
      checkOutput("rst_rvalid0",   rvalid0,   0);
      checkOutput("rst_rvalid1",   rvalid1,   0);
   endtask

   // One clock: check grants mid-cycle, advance the model on the edge, then check registered outputs.
   task automatic applyStimulus();
      bit                eg0, eg1, ev0, ev1;
      logic [DATA_W-1:0] ed;
      rd_t               e;
      @(negedge clk_in);
      eg0 = mArb && !clr && req0 && (!req1 || !mPrio);
      eg1 = mArb && !clr && req1 && (!req0 ||  mPrio);
      dutG0 = gnt0;
      dutG1 = gnt1;
      checkOutput("gnt0", gnt0, eg0);
      checkOutput("gnt1", gnt1, eg1);
      lastG0 = eg0;
      lastG1 = eg1;
      @(posedge clk_in);
      if (!rst) begin
         modelReset();
      end else begin
         cyc++;
         if (!mArb) begin
            expEna  = 1'b1;
            expWea  = 1'b1;
            expAddr = ADDR_W'(mClrIdx);
            expDin  = '0;
            mClrIdx++;
            if (mClrIdx == DEPTH) begin
               mArb    = 1'b1;
               mClrIdx = 0;
            end
         end else if (clr) begin
            mArb   = 1'b0;
            expEna = 1'b0;
            expWea = 1'b0;
            foreach (mMem[i]) mMem[i] = '0;
         end else if (eg0 || eg1) begin
            expEna  = 1'b1;
            expWea  = eg0 ? we0 : we1;
            expAddr = eg0 ? addr0 : addr1;
            expDin  = eg0 ? wdata0 : wdata1;
            if (expWea) mMem[expAddr] = expDin;
            else        rdQ.push_back('{eg0 ? 0 : 1, cyc + RD_LAT, mMem[expAddr]});
            mPrio = eg0;
         end else begin
            expEna = 1'b0;
            expWea = 1'b0;
         end
      end
      #1;
      checkOutput("ram_ena",   ram_ena,   expEna);
      checkOutput("ram_wea",   ram_wea,   expWea);
      checkOutput("ram_addr",  ram_addr,  expAddr);
      checkOutput("ram_din",   ram_din,   expDin);
      checkOutput("init_done", init_done, mArb);
      ev0 = 1'b0;
      ev1 = 1'b0;
      ed  = '0;
      if (rdQ.size() > 0 && rdQ[0].due == cyc) begin
         e   = rdQ.pop_front();
         ev0 = (e.port == 0);
         ev1 = (e.port == 1);
         ed  = e.data;
      end
      checkOutput("rvalid0", rvalid0, ev0);
      checkOutput("rvalid1", rvalid1, ev1);
      if (ev0) checkOutput("rdata0", rdata0, ed);
      if (ev1) checkOutput("rdata1", rdata1, ed);
   endtask

   // Holds a request until the DUT grants it, with a bounded wait.
   task automatic doAccess(input int port, input bit we, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d);
      bit got;
      got = 1'b0;
      if (port == 0) begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
      else           begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
      for (int n = 0; n < 24 && !got; n++) begin
         applyStimulus();
         got = (port == 0) ? (dutG0 === 1'b1) : (dutG1 === 1'b1);
      end
      if (!got) checkOutput("grant_timeout", 0, 1);
      req0 = 1'b0;
      req1 = 1'b0;
   endtask

   task automatic idle(input int n);
      req0 = 1'b0;
      req1 = 1'b0;
      clr  = 1'b0;
      repeat (n) applyStimulus();
   endtask

   // Overall time bound in case the design never grants.
   initial begin
      #200000;
      nErrors++;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
      $finish;
   end

   initial begin
      nChecks = 0;
      nErrors = 0;
      cyc     = 0;
      lastG0  = 1'b0;
      lastG1  = 1'b0;
      modelReset();

      // Reset state with both requests raised, then the full clear sweep with no grants.
      req0 = 1'b1;
      req1 = 1'b1;
      #12;
      checkResetState();
      @(posedge clk_in);
      #1 rst = 1'b1;
      repeat (DEPTH) applyStimulus();
      idle(2);

      $display("[TB] port 0 write then read-back");
      doAccess(0, 1'b1, 4'd3, 16'h00FF);
      doAccess(0, 1'b0, 4'd3, 16'h0000);
      idle(3);

      $display("[TB] contention, both ports requesting");
      req0 = 1'b1; we0 = 1'b0; addr0 = 4'd5;
      req1 = 1'b1; we1 = 1'b0; addr1 = 4'd9;
      repeat (6) applyStimulus();
      idle(3);

      $display("[TB] clear then port 1 back-to-back reads");
      doAccess(1, 1'b1, 4'd1, 16'hBEEF);
      clr = 1'b1;
      applyStimulus();
      clr = 1'b0;
      repeat (DEPTH) applyStimulus();
      for (int i = 0; i < 4; i++) doAccess(1, 1'b0, ADDR_W'(i), 16'h0000);
      idle(3);

      $display("[TB] read in flight across a clear pulse");
      doAccess(0, 1'b1, 4'd2, 16'h1234);
      doAccess(0, 1'b0, 4'd2, 16'h0000);
      clr  = 1'b1;
      req0 = 1'b1;
      applyStimulus();
      clr = 1'b0;
      repeat (DEPTH + 1) applyStimulus();
      idle(3);

      $display("[TB] randomized traffic");
      for (int i = 0; i < 400; i++) begin
         if (!req0 || lastG0) begin
            req0 = 1'($urandom_range(0, 1)); we0 = 1'($urandom_range(0, 1));
            addr0 = ADDR_W'($urandom_range(0, DEPTH - 1)); wdata0 = DATA_W'($urandom);
         end
         if (!req1 || lastG1) begin
            req1 = 1'($urandom_range(0, 1)); we1 = 1'($urandom_range(0, 1));
            addr1 = ADDR_W'($urandom_range(0, DEPTH - 1)); wdata1 = DATA_W'($urandom);
         end
         clr = ($urandom_range(0, 63) == 0);
         applyStimulus();
      end
      idle(DEPTH + 4);

      $display("[TB] asynchronous reset mid-clear");
      clr = 1'b1;
      applyStimulus();
      clr = 1'b0;
      repeat (5) applyStimulus();
      #2 rst = 1'b0;
      #1 checkResetState();
      modelReset();
      repeat (2) applyStimulus();
      rst = 1'b1;
      repeat (DEPTH) applyStimulus();
      idle(1);

      $display("[TB] asynchronous reset mid-read");
      doAccess(1, 1'b0, 4'd7, 16'h0000);
      #2 rst = 1'b0;
      #1 checkResetState();
      modelReset();
      repeat (3) applyStimulus();
      rst = 1'b1;
      repeat (DEPTH) applyStimulus();
      doAccess(0, 1'b1, 4'd7, 16'hA5A5);
      doAccess(1, 1'b0, 4'd7, 16'h0000);
      idle(3);

      $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
      $finish;
   end

endmodule
